// File: rtl/riscv_pkg.sv
// Shared RISC-V execution-unit definitions: data width, divide opcodes and divider FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left by one and keep the trial
// difference against the divisor when it does not borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so the shifted value fits in XLEN+1 bits and
  // the top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit with a registered one-cycle
// register-file write-back request.
module div_unit #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_we,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Handshake: start is taken only on an edge where busy=0 and flush=0; there
  // is no queueing, and wb_addr/wb_data are meaningful only while wb_we=1.
  div_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q, res_q;
  logic [XLEN-1:0]  rem_nx, quo_nx;
  logic [XLEN-1:0]  quo_fix, rem_fix;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_quo_q, neg_rem_q;

  logic accept, signed_op, div_zero, overflow, special;

  always_comb begin
    signed_op = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    div_zero  = (rs2_val == '0);
    overflow  = signed_op && (rs1_val == MIN_NEG) && (rs2_val == '1);
    special   = div_zero || overflow;
    accept    = (state_q == IDLE) && start && !flush;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: begin
        if (flush)                          state_d = IDLE;
        else if (cnt_q == CNT_W'(1))        state_d = FIX;
      end
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      op_q      <= DIV_OP_DIV;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= op;
          rd_q      <= rd_addr;
          cnt_q     <= CNT_W'(XLEN);
          rem_q     <= '0;
          quo_q     <= (signed_op && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
          dvs_q     <= (signed_op && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
          neg_quo_q <= signed_op && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
          neg_rem_q <= signed_op && rs1_val[XLEN-1];
          // Special results are final at accept, so CALC/FIX are skipped.
          if (div_zero)      res_q <= op[1] ? rs1_val : '1;
          else if (overflow) res_q <= op[1] ? '0 : MIN_NEG;
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX:  res_q <= op_q[1] ? rem_fix : quo_fix;
        default: ;
      endcase
    end
  end

  // Write-back is registered out of DONE; flush no longer has any effect here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      done  <= (state_q == DONE);
      wb_we <= (state_q == DONE) && (rd_q != 5'd0);
      if (state_q == DONE) begin
        wb_addr <= rd_q;
        wb_data <= res_q;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with hand-computed results and latencies.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_vec;
  int n_err;

  div_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; optional stray start pulses while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input bit noisy);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      if (noisy) begin
        start   = ((n % 7) == 3);
        op      = 2'b01;
        rs1_val = 32'd50;
        rs2_val = 32'd5;
        rd_addr = 5'd7;
      end
    end
    start = 1'b0;
    check({tag, "_lat"},  32'(n), 32'(exp_lat));
    check({tag, "_we"},   32'(wb_we), 32'(rd != 5'd0));
    check({tag, "_addr"}, 32'(wb_addr), 32'(rd));
    check({tag, "_data"}, wb_data, exp_data);
    @(posedge clk);
    #1;
    check({tag, "_done1"}, {30'd0, done, wb_we}, 32'd0);
    check({tag, "_idle"},  32'(busy), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    op = 2'b00; rs1_val = '0; rs2_val = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {29'd0, done, wb_we, 1'b0}, 32'd0);
    check("rst_addr", 32'(wb_addr), 32'd0);
    check("rst_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // normal path, 34 edges from accept to done
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2, 34, 1'b0);
    run_op("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFF, 34, 1'b0);
    run_op("div_100_m7", 2'b00, 32'd100, 32'hFFFFFFF9, 5'd4, 32'hFFFFFFF2, 34, 1'b0);
    run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFFFFF9, 5'd4, 32'd2, 34, 1'b0);
    run_op("remu_max_16", 2'b11, 32'hFFFFFFFF, 32'd16, 5'd31, 32'h0000000F, 34, 1'b0);
    run_op("div_min_1",  2'b00, 32'h80000000, 32'd1, 5'd8, 32'h80000000, 34, 1'b0);

    // special cases complete one edge after accept
    run_op("divu_by0",  2'b01, 32'h1234, 32'd0, 5'd6, 32'hFFFFFFFF, 1, 1'b0);
    run_op("rem_by0",   2'b10, 32'h1234, 32'd0, 5'd6, 32'h1234, 1, 1'b0);
    run_op("div_ovf",   2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd2, 32'd0, 1, 1'b0);

    // x0 destination with stray starts while busy
    run_op("div_x0", 2'b00, 32'd10, 32'd3, 5'd0, 32'd3, 34, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("x0_no_queue", 32'(busy), 32'd0);

    // flush together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; rs1_val = 32'd9; rs2_val = 32'd3; rd_addr = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 32'(busy), 32'd0);

    // flush on the 10th CALC edge
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_outs", {30'd0, done, wb_we}, 32'd0);
    run_op("after_flush", 2'b01, 32'd1000, 32'd10, 5'd9, 32'd100, 34, 1'b0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1_val = 32'd77; rs2_val = 32'd5; rd_addr = 5'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_outs", {30'd0, done, wb_we}, 32'd0);
    check("arst_data", wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div_m100_7", 2'b00, 32'hFFFFFF9C, 32'd7, 5'd12, 32'hFFFFFFF2, 34, 1'b0);
    run_op("rem_m100_7", 2'b10, 32'hFFFFFF9C, 32'd7, 5'd12, 32'hFFFFFFFE, 34, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
